// File: rtl/lsu_pkg.sv
// Shared types, default widths and effective-address helper for the load/store unit.
// Also used by the instruction fetch unit through lsu_addr_gen.
package lsu_pkg;

   localparam int LSU_DATA_W    = 16;
   localparam int LSU_ADDR_W    = 16;
   localparam int LSU_OFFSET_W  = 6;
   localparam int LSU_MEM_DEPTH = 8;
   localparam int LSU_EA_W      = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } lsu_state_t;

   // base + sign_extend(offset[off_w-1:0]); caller truncates to its address width
   function automatic logic [LSU_EA_W-1:0] calc_ea(input logic [LSU_EA_W-1:0] base,
                                                   input logic [LSU_EA_W-1:0] offset,
                                                   input int off_w);
      logic [LSU_EA_W-1:0] hi_mask;
      hi_mask = '1 << off_w;
      if (((offset >> (off_w - 1)) & 1) != 0)
         return base + (offset | hi_mask);
      return base + (offset & ~hi_mask);
   endfunction

endpackage

// File: rtl/lsu_addr_gen.sv
// Effective address generation: base + signed offset, wrapping at the address width.
// Combinational, zero latency, no backpressure.
// LSU_FAULT_EN: flags ea >= MEM_DEPTH as a fault; otherwise ea aliases into memory.
module lsu_addr_gen
   import lsu_pkg::*;
#(
   parameter int ADDR_W    = LSU_ADDR_W,
   parameter int OFFSET_W  = LSU_OFFSET_W,
   parameter int MEM_DEPTH = LSU_MEM_DEPTH
) (
   input  logic [ADDR_W-1:0]   base,
   input  logic [OFFSET_W-1:0] offset,
   output logic [ADDR_W-1:0]   addr,
   output logic                fault
);

   logic [ADDR_W-1:0] ea;

   assign ea = ADDR_W'(calc_ea(LSU_EA_W'(base), LSU_EA_W'(offset), OFFSET_W));

`ifdef LSU_FAULT_EN
   assign addr  = ea;
   assign fault = (ea >= ADDR_W'(MEM_DEPTH));
`else
   // MEM_DEPTH is a power of two, so the mask keeps the low index bits only
   assign addr  = ea & ADDR_W'(MEM_DEPTH - 1);
   assign fault = 1'b0;
`endif

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator: one request -> one single-cycle data memory access -> one response.
// Latency: accept at edge 0, ACCESS in cycle 1, resp_valid from cycle 2; 3 cycles per op.
// Backpressure: req_ready only in IDLE; response held stable until resp_ready (LSU_FAULT_EN adds range faults).
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DATA_W    = LSU_DATA_W,
   parameter int ADDR_W    = LSU_ADDR_W,
   parameter int OFFSET_W  = LSU_OFFSET_W,
   parameter int MEM_DEPTH = LSU_MEM_DEPTH
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_is_store,
   input  logic [ADDR_W-1:0]   req_base,
   input  logic [OFFSET_W-1:0] req_offset,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                resp_fault,
   output logic                stall,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W-1:0]   mem_write_data,
   output logic                mem_write_enable,
   output logic                mem_read_enable,
   input  logic [DATA_W-1:0]   mem_read_data
);

   lsu_state_t        state;
   logic              op_store;
   logic              op_fault;
   logic [ADDR_W-1:0] ag_addr;
   logic              ag_fault;

   lsu_addr_gen #(
      .ADDR_W   (ADDR_W),
      .OFFSET_W (OFFSET_W),
      .MEM_DEPTH(MEM_DEPTH)
   ) u_addr_gen (
      .base  (req_base),
      .offset(req_offset),
      .addr  (ag_addr),
      .fault (ag_fault)
   );

   assign req_ready = rst_n && (state == IDLE);
   assign stall     = req_valid && !req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         op_store         <= 1'b0;
         op_fault         <= 1'b0;
         mem_address      <= '0;
         mem_write_data   <= '0;
         mem_write_enable <= 1'b0;
         mem_read_enable  <= 1'b0;
         resp_valid       <= 1'b0;
         resp_fault       <= 1'b0;
         resp_rdata       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  mem_address      <= ag_addr;
                  mem_write_data   <= req_wdata;
                  op_store         <= req_is_store;
                  op_fault         <= ag_fault;
                  // a faulting request still spends a dead ACCESS cycle to keep latency fixed
                  mem_write_enable <= req_is_store && !ag_fault;
                  mem_read_enable  <= !req_is_store && !ag_fault;
                  state            <= ACCESS;
               end
            end
            ACCESS: begin
               mem_write_enable <= 1'b0;
               mem_read_enable  <= 1'b0;
               resp_valid       <= 1'b1;
               resp_fault       <= op_fault;
               resp_rdata       <= (op_store || op_fault) ? '0 : mem_read_data;
               state            <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  resp_fault <= 1'b0;
                  resp_rdata <= '0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a local 8-word data memory and a reference copy.
module tb_load_store_unit;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_is_store;
   logic [15:0] req_base;
   logic [5:0]  req_offset;
   logic [15:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [15:0] resp_rdata;
   logic        resp_fault;
   logic        stall;
   logic [15:0] mem_address;
   logic [15:0] mem_write_data;
   logic        mem_write_enable;
   logic        mem_read_enable;
   logic [15:0] mem_read_data;

   logic [15:0] mem [8];
   logic [15:0] ref_mem [8];
   logic        init_done;
   int          cyc;
   int          nvec;
   int          nerr;

   load_store_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_is_store    (req_is_store),
      .req_base        (req_base),
      .req_offset      (req_offset),
      .req_wdata       (req_wdata),
      .resp_valid      (resp_valid),
      .resp_ready      (resp_ready),
      .resp_rdata      (resp_rdata),
      .resp_fault      (resp_fault),
      .stall           (stall),
      .mem_address     (mem_address),
      .mem_write_data  (mem_write_data),
      .mem_write_enable(mem_write_enable),
      .mem_read_enable (mem_read_enable),
      .mem_read_data   (mem_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 8; i++) mem[i] <= 16'h1000 + 16'(i);
      end else if (mem_write_enable) begin
         mem[mem_address[2:0]] <= mem_write_data;
      end
   end

   assign mem_read_data = mem[mem_address[2:0]];

   task automatic do_req(input string name, input logic st, input logic [15:0] base,
                         input logic [5:0] off, input logic [15:0] wd,
                         input logic [15:0] exp_addr, input logic exp_fault,
                         input logic [15:0] exp_rdata, input int hold, output int resp_cyc);
      @(negedge clk);
      nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL %s req_ready_idle: got %b want 1", name, req_ready); end
      nvec++; if ({mem_write_enable, mem_read_enable} !== 2'b00) begin nerr++; $display("FAIL %s strobes_idle: got %b want 00", name, {mem_write_enable, mem_read_enable}); end
      req_valid = 1'b1; req_is_store = st; req_base = base; req_offset = off; req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0;
      nvec++; if (req_ready !== 1'b0) begin nerr++; $display("FAIL %s req_ready_access: got %b want 0", name, req_ready); end
      nvec++; if (resp_valid !== 1'b0) begin nerr++; $display("FAIL %s resp_valid_access: got %b want 0", name, resp_valid); end
      nvec++; if (mem_write_enable !== (st && !exp_fault)) begin nerr++; $display("FAIL %s we_access: got %b want %b", name, mem_write_enable, st && !exp_fault); end
      nvec++; if (mem_read_enable !== (!st && !exp_fault)) begin nerr++; $display("FAIL %s re_access: got %b want %b", name, mem_read_enable, !st && !exp_fault); end
      if (!exp_fault) begin
         nvec++; if (mem_address !== exp_addr) begin nerr++; $display("FAIL %s mem_address: got %h want %h", name, mem_address, exp_addr); end
      end
      if (st && !exp_fault) begin
         nvec++; if (mem_write_data !== wd) begin nerr++; $display("FAIL %s mem_write_data: got %h want %h", name, mem_write_data, wd); end
         ref_mem[exp_addr[2:0]] = wd;
      end
      @(negedge clk);
      resp_cyc = cyc;
      nvec++; if (resp_valid !== 1'b1) begin nerr++; $display("FAIL %s resp_valid: got %b want 1", name, resp_valid); end
      nvec++; if (resp_rdata !== exp_rdata) begin nerr++; $display("FAIL %s resp_rdata: got %h want %h", name, resp_rdata, exp_rdata); end
      nvec++; if (resp_fault !== exp_fault) begin nerr++; $display("FAIL %s resp_fault: got %b want %b", name, resp_fault, exp_fault); end
      nvec++; if ({mem_write_enable, mem_read_enable} !== 2'b00) begin nerr++; $display("FAIL %s strobes_resp: got %b want 00", name, {mem_write_enable, mem_read_enable}); end
      if (hold > 0) begin
         resp_ready = 1'b0;
         req_valid = 1'b1; req_is_store = 1'b1; req_base = 16'h0000; req_offset = 6'h00; req_wdata = 16'hDEAD;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            nvec++; if (resp_valid !== 1'b1) begin nerr++; $display("FAIL %s hold%0d resp_valid: got %b want 1", name, i, resp_valid); end
            nvec++; if (resp_rdata !== exp_rdata) begin nerr++; $display("FAIL %s hold%0d resp_rdata: got %h want %h", name, i, resp_rdata, exp_rdata); end
            nvec++; if (req_ready !== 1'b0) begin nerr++; $display("FAIL %s hold%0d req_ready: got %b want 0", name, i, req_ready); end
            nvec++; if (stall !== 1'b1) begin nerr++; $display("FAIL %s hold%0d stall: got %b want 1", name, i, stall); end
         end
         req_valid = 1'b0;
         resp_ready = 1'b1;
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      init_done = 1'b1;
      for (int i = 0; i < 8; i++) ref_mem[i] = 16'h1000 + 16'(i);
      nvec++; if (req_ready !== 1'b0) begin nerr++; $display("FAIL rst req_ready: got %b want 0", req_ready); end
      nvec++; if (resp_valid !== 1'b0) begin nerr++; $display("FAIL rst resp_valid: got %b want 0", resp_valid); end
      nvec++; if (resp_fault !== 1'b0) begin nerr++; $display("FAIL rst resp_fault: got %b want 0", resp_fault); end
      nvec++; if (resp_rdata !== 16'h0) begin nerr++; $display("FAIL rst resp_rdata: got %h want 0000", resp_rdata); end
      nvec++; if ({mem_write_enable, mem_read_enable} !== 2'b00) begin nerr++; $display("FAIL rst strobes: got %b want 00", {mem_write_enable, mem_read_enable}); end
      nvec++; if (mem_address !== 16'h0) begin nerr++; $display("FAIL rst mem_address: got %h want 0000", mem_address); end
      nvec++; if (mem_write_data !== 16'h0) begin nerr++; $display("FAIL rst mem_write_data: got %h want 0000", mem_write_data); end
      rst_n = 1'b1;
      #1;
      nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL rst_release req_ready: got %b want 1", req_ready); end
   endtask

   task automatic test_store_load();
      int rc;
      do_req("st_b2_o1", 1'b1, 16'd2, 6'd1, 16'hBEEF, 16'd3, 1'b0, 16'h0000, 0, rc);
      do_req("ld_b3_o0", 1'b0, 16'd3, 6'd0, 16'h0000, 16'd3, 1'b0, 16'hBEEF, 0, rc);
   endtask

   task automatic test_backpressure();
      int rc;
      do_req("ld_b5_om2", 1'b0, 16'd5, 6'h3E, 16'h0000, 16'd3, 1'b0, 16'hBEEF, 4, rc);
   endtask

   task automatic test_out_of_range();
      int rc;
`ifdef LSU_FAULT_EN
      do_req("ld_ea8", 1'b0, 16'd7, 6'd1, 16'h0000, 16'd8, 1'b1, 16'h0000, 0, rc);
      do_req("ld_eaffff", 1'b0, 16'd0, 6'h3F, 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 0, rc);
`else
      do_req("ld_ea8", 1'b0, 16'd7, 6'd1, 16'h0000, 16'd0, 1'b0, 16'h1000, 0, rc);
      do_req("ld_eaffff", 1'b0, 16'd0, 6'h3F, 16'h0000, 16'd7, 1'b0, 16'h1007, 0, rc);
`endif
      do_req("ld_last", 1'b0, 16'd6, 6'd1, 16'h0000, 16'd7, 1'b0, 16'h1007, 0, rc);
   endtask

   task automatic test_reset_mid_access();
      @(negedge clk);
      req_valid = 1'b1; req_is_store = 1'b1; req_base = 16'd4; req_offset = 6'd0; req_wdata = 16'h5A5A;
      @(negedge clk);
      req_valid = 1'b0;
      nvec++; if (mem_write_enable !== 1'b1) begin nerr++; $display("FAIL midrst we_before: got %b want 1", mem_write_enable); end
      #1 rst_n = 1'b0;
      #1;
      nvec++; if ({mem_write_enable, mem_read_enable} !== 2'b00) begin nerr++; $display("FAIL midrst strobes: got %b want 00", {mem_write_enable, mem_read_enable}); end
      nvec++; if (req_ready !== 1'b0) begin nerr++; $display("FAIL midrst req_ready: got %b want 0", req_ready); end
      @(negedge clk);
      nvec++; if (mem[4] !== ref_mem[4]) begin nerr++; $display("FAIL midrst mem4: got %h want %h", mem[4], ref_mem[4]); end
      rst_n = 1'b1;
      #1;
      nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL midrst req_ready_after: got %b want 1", req_ready); end
      nvec++; if (resp_valid !== 1'b0) begin nerr++; $display("FAIL midrst resp_valid_after: got %b want 0", resp_valid); end
   endtask

   task automatic test_back_to_back();
      int          rc;
      int          prev;
      logic        st;
      logic        f;
      logic [15:0] base;
      logic [5:0]  off;
      logic [15:0] wd;
      logic [15:0] ea;
      logic [15:0] addr;
      logic [15:0] exp_rd;
      prev = 0;
      for (int i = 0; i < 10; i++) begin
         st   = 1'($urandom_range(0, 1));
         base = 16'($urandom_range(0, 9));
         off  = 6'($urandom_range(0, 63));
         wd   = 16'($urandom);
         ea   = base + {{10{off[5]}}, off};
`ifdef LSU_FAULT_EN
         f    = (ea >= 16'd8);
         addr = ea;
`else
         f    = 1'b0;
         addr = ea & 16'd7;
`endif
         exp_rd = (st || f) ? 16'h0000 : ref_mem[addr[2:0]];
         do_req($sformatf("b2b%0d", i), st, base, off, wd, addr, f, exp_rd, 0, rc);
         if (i > 0) begin
            nvec++; if (rc - prev !== 3) begin nerr++; $display("FAIL b2b%0d cadence: got %0d want 3", i, rc - prev); end
         end
         prev = rc;
      end
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         nvec++; if (mem[i] !== ref_mem[i]) begin nerr++; $display("FAIL b2b mem%0d: got %h want %h", i, mem[i], ref_mem[i]); end
      end
   endtask

   initial begin
      rst_n = 1'b0; init_done = 1'b0; cyc = 0; nvec = 0; nerr = 0;
      req_valid = 1'b0; req_is_store = 1'b0; req_base = '0; req_offset = '0; req_wdata = '0;
      resp_ready = 1'b1;
      test_reset();
      test_store_load();
      test_backpressure();
      test_out_of_range();
      test_reset_mid_access();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
